// File: rtl/ctrl_div_if.sv
// ctrl_div_if: handshake and strobe bundle between the divider controller,
// the surrounding system and the dp_div datapath.
// slave  = controller side, master = system/datapath side.
interface ctrl_div_if;
  logic start;
  logic div_zero;
  logic R_gte_B;
  logic load;
  logic subtract;
  logic inc_Q;
  logic busy;
  logic done;
  logic valid;
  logic err_div0;
  logic err_wdog;

  modport slave (
    input  start, div_zero, R_gte_B,
    output load, subtract, inc_Q, busy, done, valid, err_div0, err_wdog
  );

  modport master (
    output start, div_zero, R_gte_B,
    input  load, subtract, inc_Q, busy, done, valid, err_div0, err_wdog
  );
endinterface

// File: rtl/ctrl_div.sv
// ctrl_div: sequencing FSM for the restoring-subtraction divider dp_div.
// IDLE -> LOAD -> CHECK (subtract loop) -> DONE | ERR -> IDLE.
// Optional watchdog on the CHECK loop: define CTRL_DIV_WDOG_EN.
module ctrl_div #(
  parameter logic [8:0] WDOG_LIMIT = 9'd300
) (
  input logic       clk,
  input logic       reset,
  ctrl_div_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_sub;
  logic       w_wdog_trip;
  logic       r_valid;

`ifdef CTRL_DIV_WDOG_EN
  logic [8:0] r_wdog_cnt;
  logic       r_wdog_hit;

  // Trip on the CHECK cycle whose increment would make the count reach the limit.
  assign w_wdog_trip = (r_wdog_cnt == (WDOG_LIMIT - 9'd1));

  // Watchdog counter: cleared in LOAD, counts CHECK cycles; remembers why ERR was entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt <= 9'd0;
      r_wdog_hit <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_wdog_cnt <= 9'd0;
      end else if (r_state == S_CHECK) begin
        r_wdog_cnt <= r_wdog_cnt + 9'd1;
      end else begin
        r_wdog_cnt <= r_wdog_cnt;
      end
      r_wdog_hit <= (r_state == S_CHECK) && !bus.div_zero && w_wdog_trip;
    end
  end

  assign bus.err_wdog = (r_state == S_ERR) && r_wdog_hit;
  assign bus.err_div0 = (r_state == S_ERR) && !r_wdog_hit;
`else
  logic [8:0] w_unused_wdog_limit;

  assign w_unused_wdog_limit = WDOG_LIMIT;
  assign w_wdog_trip         = 1'b0;
  assign bus.err_wdog        = 1'b0;
  assign bus.err_div0        = (r_state == S_ERR);
`endif

  // Next-state decode; CHECK also produces the Mealy subtract/inc_Q strobe.
  always_comb begin
    w_next = r_state;
    w_sub  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        w_next = S_CHECK;
      end
      S_CHECK: begin
        if (bus.div_zero) begin
          w_next = S_ERR;
        end else if (w_wdog_trip) begin
          w_next = S_ERR;
        end else if (bus.R_gte_B) begin
          w_next = S_CHECK;
          w_sub  = 1'b1;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Result-valid level: cleared when a new division is accepted, set leaving DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_valid <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Strobes are gated by reset so the datapath stops in the reset cycle itself.
  assign bus.load     = (r_state == S_LOAD) && !reset;
  assign bus.subtract = w_sub && !reset;
  assign bus.inc_Q    = w_sub && !reset;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.valid    = r_valid;

endmodule

// File: tb/tb_ctrl_div.sv
// tb_ctrl_div: self-checking bench for ctrl_div with a behavioural dp_div
// model and a scoreboard of expected division outcomes.
module tb_ctrl_div;
  localparam int WL = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ctrl_div_if bus_if ();

  ctrl_div #(.WDOG_LIMIT(9'd20)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  // behavioural datapath
  logic [7:0] a_in, b_in, m_r, m_b, m_q;
  logic force_gte;

  assign bus_if.div_zero = (m_b == 8'd0);
  assign bus_if.R_gte_B  = force_gte | (m_r >= m_b);

  always @(posedge clk) begin
    if (reset) begin
      m_b <= 8'd1; m_r <= 8'd0; m_q <= 8'd0;
    end else if (bus_if.load) begin
      m_b <= b_in; m_r <= a_in; m_q <= 8'd0;
    end else begin
      if (bus_if.subtract) m_r <= m_r - m_b;
      if (bus_if.inc_Q)    m_q <= m_q + 8'd1;
    end
  end

  typedef struct {
    int lat; int q; int r; bit e0; bit ew; bit vld; bit qr;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int pulse_at);
    exp_t e;
    int k, nsub, nload, nexcl;
    bit seen;
    e.e0 = (b == 8'd0);
    e.q  = e.e0 ? 0 : int'(a) / int'(b);
    e.r  = e.e0 ? 0 : int'(a) % int'(b);
    e.lat = e.e0 ? 3 : e.q + 3;
    e.ew = 1'b0; e.vld = !e.e0; e.qr = !e.e0;
    if (force_gte && !e.e0) begin
      e.lat = WL + 2; e.ew = 1'b1; e.vld = 1'b0; e.qr = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    a_in = a; b_in = b; bus_if.start = 1'b1;
    k = 0; nsub = 0; nload = 0; nexcl = 0; seen = 1'b0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      bus_if.start = (k == pulse_at);
      if (bus_if.load) begin
        nload++;
        if (nload == 1) check("load_cycle", k, 1);
      end
      if (bus_if.subtract) nsub++;
      if ((bus_if.load && (bus_if.subtract || bus_if.inc_Q)) || (bus_if.subtract != bus_if.inc_Q))
        nexcl++;
      if (bus_if.done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    e = sb.pop_front();
    check("done_cycle", k, e.lat);
    check("err_div0", bus_if.err_div0, e.e0);
    check("err_wdog", bus_if.err_wdog, e.ew);
    check("load_count", nload, 1);
    check("strobe_excl", nexcl, 0);
    if (e.qr) begin
      check("quotient", m_q, e.q);
      check("remainder", m_r, e.r);
      check("sub_cycles", nsub, e.q);
    end
    if (e.e0) check("sub_cycles_div0", nsub, 0);
    @(negedge clk);
    check("valid_after", bus_if.valid, e.vld);
    check("busy_after", bus_if.busy, 0);
  endtask

  initial begin
    int k, kd, kl2, nl;
    bus_if.start = 1'b0; a_in = 8'd0; b_in = 8'd1; force_gte = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_valid", bus_if.valid, 0);
    check("rst_strobes", {bus_if.load, bus_if.subtract, bus_if.inc_Q}, 0);
    check("rst_err", {bus_if.err_div0, bus_if.err_wdog}, 0);
    reset = 1'b0;
    @(negedge clk);

    run_div(8'd100, 8'd7, 5);
    run_div(8'd5, 8'd9, 0);
    run_div(8'd42, 8'd0, 0);
    run_div(8'd255, 8'd1, 0);

    // start held high: back-to-back divisions
    @(negedge clk);
    a_in = 8'd5; b_in = 8'd9; bus_if.start = 1'b1;
    k = 0; kd = -1; kl2 = -1; nl = 0;
    while (kl2 < 0 && k < 50) begin
      @(negedge clk);
      k++;
      if (bus_if.load) begin
        nl++;
        if (nl == 2) begin
          kl2 = k;
          check("b2b_valid_at_load", bus_if.valid, 0);
        end
      end
      if (bus_if.done && kd < 0) kd = k;
      if (kd >= 0 && k == kd + 1) check("b2b_valid_gap", bus_if.valid, 1);
    end
    check("b2b_first_done", kd, 3);
    check("b2b_gap", kl2 - kd, 2);
    bus_if.start = 1'b0;
    k = 0;
    while (!bus_if.done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b_second_done", bus_if.done, 1);
    @(negedge clk);

    // reset during CHECK
    @(negedge clk);
    a_in = 8'd200; b_in = 8'd3; bus_if.start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    check("pre_rst_sub", bus_if.subtract, 1);
    reset = 1'b1;
    #1;
    check("rst_strobe_drop", {bus_if.load, bus_if.subtract, bus_if.inc_Q}, 0);
    @(negedge clk);
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_strobes", {bus_if.load, bus_if.subtract, bus_if.inc_Q}, 0);
    check("midrst_valid", bus_if.valid, 0);
    check("midrst_done", bus_if.done, 0);
    reset = 1'b0;
    @(negedge clk);

    run_div(8'd17, 8'd4, 0);

`ifdef CTRL_DIV_WDOG_EN
    force_gte = 1'b1;
    run_div(8'd50, 8'd3, 0);
    force_gte = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
